// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the control unit and its instruction decoder:
//   - opcode values (instruction byte bits [7:4])
//   - accumulator input mux selections
//   - sequencer state encoding and the debug snapshot struct
//   - two_byte(): tells whether an opcode carries an operand byte
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_IN   = 4'h1;
    localparam logic [3:0] OP_OUT  = 4'h2;
    localparam logic [3:0] OP_LDR  = 4'h3;
    localparam logic [3:0] OP_STR  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_ALU  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_JP   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] MUX_ALU  = 2'd0;
    localparam logic [1:0] MUX_RF   = 2'd1;
    localparam logic [1:0] MUX_IMM  = 2'd2;
    localparam logic [1:0] MUX_USER = 2'd3;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_OPERAND = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    // Snapshot of the sequencer internals, brought out for observation.
    typedef struct packed {
        state_t     state;
        logic [7:0] ir;
        logic [7:0] opr;
        logic       zflag;
        logic       pflag;
    } cpu_dbg_t;

    // LDI, ALU, JMP, JZ and JP are followed by an operand byte.
    function automatic logic two_byte(input logic [3:0] opcode);
        return (opcode >= OP_LDI) && (opcode <= OP_JP);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational decode of the latched instruction (opcode, register
// field) and operand byte into datapath control fields.
//   opcode, reg_n      : latched instruction byte fields
//   opr                : latched operand byte
//   fetch_opcode       : opcode currently presented by the ROM (FETCH decision)
//   exec_en            : 1 only while executing (and not in reset); all
//                        enables/selects stay 0 otherwise
//   user_enter         : user input strobe, drives acc_enable during IN
//   mux_select .. alu_num_rotate : datapath controls
//   is_two_byte        : fetch_opcode carries an operand byte
//   is_jump/in/out/halt: class of the latched opcode
// -----------------------------------------------------------------------------
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] reg_n,
    input  logic [7:0] opr,
    input  logic [3:0] fetch_opcode,
    input  logic       exec_en,
    input  logic       user_enter,
    output logic [1:0] mux_select,
    output logic [7:0] imm_data,
    output logic       acc_enable,
    output logic [2:0] rf_address,
    output logic       rf_write,
    output logic [3:0] alu_select,
    output logic [1:0] alu_num_rotate,
    output logic       is_two_byte,
    output logic       is_jump,
    output logic       is_in,
    output logic       is_out,
    output logic       is_halt
);

    always_comb begin
        mux_select = MUX_ALU;
        imm_data   = 8'h00;
        acc_enable = 1'b0;
        rf_write   = 1'b0;
        if (exec_en) begin
            case (opcode)
                OP_IN: begin
                    mux_select = MUX_USER;
                    acc_enable = user_enter;
                end
                OP_LDR: begin
                    mux_select = MUX_RF;
                    acc_enable = 1'b1;
                end
                OP_STR: begin
                    rf_write = 1'b1;
                end
                OP_LDI: begin
                    mux_select = MUX_IMM;
                    imm_data   = opr;
                    acc_enable = 1'b1;
                end
                OP_ALU: begin
                    mux_select = MUX_ALU;
                    acc_enable = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign rf_address     = reg_n;
    assign alu_select     = opr[3:0];
    assign alu_num_rotate = opr[5:4];
    assign is_two_byte    = two_byte(fetch_opcode);
    assign is_jump        = (opcode == OP_JMP) || (opcode == OP_JZ) || (opcode == OP_JP);
    assign is_in          = (opcode == OP_IN);
    assign is_out         = (opcode == OP_OUT);
    assign is_halt        = (opcode == OP_HALT);

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Fetch/operand/execute sequencer for the 8-bit CPU core. Reads instructions
// from a combinational ROM, decodes them and drives the datapath controls.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   rom_addr / rom_data   : program ROM port (rom_addr is the PC)
//   user_enter            : user input strobe
//   zero_flag_in, positive_flag_in : datapath flags, captured with each
//                           accumulator load
//   mux_select, imm_data, acc_enable, rf_address, rf_write, alu_select,
//   alu_num_rotate        : datapath controls, active only in EXECUTE
//   output_enable         : output buffer enable (set by OUT, cleared by IN)
//   halted                : sequencer is in HALT
//   dbg                   : state, IR, OPR and flags for observation
//
// User input handshake: IN waits in EXECUTE for a one-cycle user_enter pulse.
// The cycle in which user_enter is high while IN executes is the transfer:
// the accumulator loads user_in on that edge and the sequencer moves on.
// Strobes at any other time are ignored; there is no back-pressure signal.
// -----------------------------------------------------------------------------
module control_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              user_enter,
    input  logic              zero_flag_in,
    input  logic              positive_flag_in,
    output logic [1:0]        mux_select,
    output logic [7:0]        imm_data,
    output logic              acc_enable,
    output logic [2:0]        rf_address,
    output logic              rf_write,
    output logic [3:0]        alu_select,
    output logic [1:0]        alu_num_rotate,
    output logic              output_enable,
    output logic              halted,
    output cpu_dbg_t          dbg
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [7:0]        ir, ir_next;
    logic [7:0]        opr, opr_next;
    logic              out_latch, out_next;
    logic              zflag, pflag;

    logic              exec_en;
    logic              is_two_byte, is_jump, is_in, is_out, is_halt;
    logic              jump_taken;
    logic [1:0]        dec_mux_select;
    logic [7:0]        dec_imm_data;
    logic              dec_acc_enable;
    logic [2:0]        dec_rf_address;
    logic              dec_rf_write;
    logic [3:0]        dec_alu_select;
    logic [1:0]        dec_alu_num_rotate;

    // Reset is folded in so an instruction caught by reset performs no write.
    assign exec_en = (state == ST_EXECUTE) && !reset;

    instr_decoder u_decoder (
        .opcode         (ir[7:4]),
        .reg_n          (ir[2:0]),
        .opr            (opr),
        .fetch_opcode   (rom_data[7:4]),
        .exec_en        (exec_en),
        .user_enter     (user_enter),
        .mux_select     (dec_mux_select),
        .imm_data       (dec_imm_data),
        .acc_enable     (dec_acc_enable),
        .rf_address     (dec_rf_address),
        .rf_write       (dec_rf_write),
        .alu_select     (dec_alu_select),
        .alu_num_rotate (dec_alu_num_rotate),
        .is_two_byte    (is_two_byte),
        .is_jump        (is_jump),
        .is_in          (is_in),
        .is_out         (is_out),
        .is_halt        (is_halt)
    );

    always_comb begin
        jump_taken = 1'b0;
        if (is_jump) begin
            case (ir[7:4])
                OP_JMP:  jump_taken = 1'b1;
                OP_JZ:   jump_taken = zflag;
                OP_JP:   jump_taken = pflag;
                default: jump_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        opr_next   = opr;
        out_next   = out_latch;
        case (state)
            ST_FETCH: begin
                ir_next    = rom_data;
                pc_next    = pc + ADDR_W'(1);
                state_next = is_two_byte ? ST_OPERAND : ST_EXECUTE;
            end
            ST_OPERAND: begin
                opr_next   = rom_data;
                pc_next    = pc + ADDR_W'(1);
                state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_next = ST_FETCH;
                if (is_halt) begin
                    state_next = ST_HALT;
                end
                if (is_in) begin
                    if (user_enter) begin
                        out_next = 1'b0;
                    end else begin
                        state_next = ST_EXECUTE;
                    end
                end
                if (is_out) begin
                    out_next = 1'b1;
                end
                // Not-taken jumps fall through: PC already points past OPR.
                if (jump_taken) begin
                    pc_next = ADDR_W'(opr);
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_FETCH;
            pc        <= ADDR_W'(RESET_PC);
            ir        <= 8'h00;
            opr       <= 8'h00;
            out_latch <= 1'b0;
            // Accumulator resets to 0, so zero and non-negative both hold.
            zflag     <= 1'b1;
            pflag     <= 1'b1;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            ir        <= ir_next;
            opr       <= opr_next;
            out_latch <= out_next;
            if (acc_enable) begin
                zflag <= zero_flag_in;
                pflag <= positive_flag_in;
            end
        end
    end

    assign rom_addr       = pc;
    assign mux_select     = dec_mux_select;
    assign imm_data       = dec_imm_data;
    assign acc_enable     = dec_acc_enable;
    assign rf_write       = dec_rf_write;
    assign rf_address     = reset ? 3'd0 : dec_rf_address;
    assign alu_select     = reset ? 4'd0 : dec_alu_select;
    assign alu_num_rotate = reset ? 2'd0 : dec_alu_num_rotate;
    assign output_enable  = out_latch && !reset;
    assign halted         = (state == ST_HALT) && !reset;
    assign dbg            = '{state: state, ir: ir, opr: opr, zflag: zflag, pflag: pflag};

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Directed bench for control_unit: a behavioural ROM array drives rom_data,
// each program is loaded, the core is reset and outputs are compared against
// hand-derived values one cycle at a time.
// -----------------------------------------------------------------------------
module tb_control_unit;
    import cpu_pkg::*;

    localparam int ADDR_W = 8;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              user_enter;
    logic              zero_flag_in;
    logic              positive_flag_in;
    logic [1:0]        mux_select;
    logic [7:0]        imm_data;
    logic              acc_enable;
    logic [2:0]        rf_address;
    logic              rf_write;
    logic [3:0]        alu_select;
    logic [1:0]        alu_num_rotate;
    logic              output_enable;
    logic              halted;
    cpu_dbg_t          dbg;

    logic [7:0]        rom [0:255];
    logic [31:0]       exp_q [$];

    int n_checks;
    int n_errors;

    assign rom_data = rom[rom_addr];

    control_unit #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
        .clock            (clock),
        .reset            (reset),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .user_enter       (user_enter),
        .zero_flag_in     (zero_flag_in),
        .positive_flag_in (positive_flag_in),
        .mux_select       (mux_select),
        .imm_data         (imm_data),
        .acc_enable       (acc_enable),
        .rf_address       (rf_address),
        .rf_write         (rf_write),
        .alu_select       (alu_select),
        .alu_num_rotate   (alu_num_rotate),
        .output_enable    (output_enable),
        .halted           (halted),
        .dbg              (dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- driver tasks ----------------
    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic run_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_jz(input logic zf, input logic [31:0] exp_pc, input string tag);
        clear_rom();
        rom[0] = 8'h50; rom[1] = 8'h00; rom[2] = 8'h80; rom[3] = 8'h10;
        zero_flag_in = zf;
        run_reset();
        step(3);
        zero_flag_in = ~zf;
        step(3);
        check(tag, 32'(rom_addr), exp_pc);
        zero_flag_in = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        user_enter = 1'b0;
        zero_flag_in = 1'b0;
        positive_flag_in = 1'b0;

        // Reset over a NOP program.
        clear_rom();
        step(2);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_acc_enable", 32'(acc_enable), 32'h0);
        check("rst_rf_write", 32'(rf_write), 32'h0);
        check("rst_output_enable", 32'(output_enable), 32'h0);
        check("rst_state", 32'(dbg.state), 32'(ST_FETCH));
        check("rst_zflag", 32'(dbg.zflag), 32'h1);
        reset = 1'b0;
        step(2);
        check("nop_rom_addr", 32'(rom_addr), 32'h1);
        check("nop_state", 32'(dbg.state), 32'(ST_FETCH));

        // LDI 5.
        clear_rom();
        rom[0] = 8'h50; rom[1] = 8'h05;
        run_reset();
        step(2);
        check("ldi_mux", 32'(mux_select), 32'h2);
        check("ldi_imm", 32'(imm_data), 32'h05);
        check("ldi_acc_en", 32'(acc_enable), 32'h1);
        step(1);
        check("ldi_next_addr", 32'(rom_addr), 32'h2);
        check("ldi_acc_off", 32'(acc_enable), 32'h0);

        // IN waits for user_enter.
        clear_rom();
        rom[0] = 8'h10;
        run_reset();
        step(1);
        for (int i = 0; i < 4; i++) begin
            check("in_wait_state", 32'(dbg.state), 32'(ST_EXECUTE));
            check("in_wait_acc", 32'(acc_enable), 32'h0);
            check("in_wait_mux", 32'(mux_select), 32'h3);
            step(1);
        end
        user_enter = 1'b1;
        zero_flag_in = 1'b0;
        positive_flag_in = 1'b1;
        #1;
        check("in_pulse_acc", 32'(acc_enable), 32'h1);
        check("in_pulse_mux", 32'(mux_select), 32'h3);
        step(1);
        user_enter = 1'b0;
        check("in_done_state", 32'(dbg.state), 32'(ST_FETCH));
        check("in_done_addr", 32'(rom_addr), 32'h1);
        check("in_zflag_captured", 32'(dbg.zflag), 32'h0);
        positive_flag_in = 1'b0;

        // Conditional jump, taken and not taken.
        run_jz(1'b1, 32'h10, "jz_taken_pc");
        run_jz(1'b0, 32'h04, "jz_fall_pc");

        // ALU 3 with ctl 0x25.
        clear_rom();
        rom[0] = 8'h63; rom[1] = 8'h25;
        run_reset();
        step(2);
        check("alu_rf_addr", 32'(rf_address), 32'h3);
        check("alu_sel", 32'(alu_select), 32'h5);
        check("alu_rot", 32'(alu_num_rotate), 32'h2);
        check("alu_mux", 32'(mux_select), 32'h0);
        check("alu_acc_en", 32'(acc_enable), 32'h1);

        // STR 4.
        clear_rom();
        rom[0] = 8'h44;
        run_reset();
        step(1);
        check("str_rf_write", 32'(rf_write), 32'h1);
        check("str_rf_addr", 32'(rf_address), 32'h4);
        check("str_acc_en", 32'(acc_enable), 32'h0);

        // OUT then HALT; reset clears both.
        clear_rom();
        rom[0] = 8'h20; rom[1] = 8'hF0;
        run_reset();
        step(1);
        check("out_oe_exec", 32'(output_enable), 32'h0);
        step(1);
        check("out_oe_c3", 32'(output_enable), 32'h1);
        step(2);
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_oe", 32'(output_enable), 32'h1);
        user_enter = 1'b1;
        step(3);
        user_enter = 1'b0;
        check("halt_persist", 32'(halted), 32'h1);
        check("halt_pc", 32'(rom_addr), 32'h2);
        reset = 1'b1;
        #1;
        check("halt_rst_halted", 32'(halted), 32'h0);
        check("halt_rst_oe", 32'(output_enable), 32'h0);
        step(1);
        reset = 1'b0;
        #1;
        check("halt_rel_oe", 32'(output_enable), 32'h0);
        check("halt_rel_state", 32'(dbg.state), 32'(ST_FETCH));

        // OUT then IN: completed IN clears the output enable.
        clear_rom();
        rom[0] = 8'h20; rom[1] = 8'h10;
        run_reset();
        step(2);
        check("outin_oe_set", 32'(output_enable), 32'h1);
        step(1);
        user_enter = 1'b1;
        step(1);
        user_enter = 1'b0;
        check("outin_oe_clr", 32'(output_enable), 32'h0);

        // Reset during IN with user_enter high: no accumulator write.
        clear_rom();
        rom[0] = 8'h10;
        run_reset();
        step(1);
        user_enter = 1'b1;
        reset = 1'b1;
        #1;
        check("rstin_acc_en", 32'(acc_enable), 32'h0);
        step(1);
        check("rstin_state", 32'(dbg.state), 32'(ST_FETCH));
        check("rstin_addr", 32'(rom_addr), 32'h0);
        reset = 1'b0;
        user_enter = 1'b0;

        // PC wrap in OPERAND: JMP 0xFE, then LDI 7 straddling 0xFF -> 0x00.
        clear_rom();
        rom[0] = 8'h70; rom[1] = 8'hFE; rom[254] = 8'h50; rom[255] = 8'h07;
        run_reset();
        exp_q.push_back(32'h01);
        exp_q.push_back(32'h02);
        exp_q.push_back(32'hFE);
        exp_q.push_back(32'hFF);
        exp_q.push_back(32'h00);
        while (exp_q.size() > 0) begin
            step(1);
            check("wrap_pc", 32'(rom_addr), exp_q.pop_front());
        end
        check("wrap_imm", 32'(imm_data), 32'h07);
        check("wrap_acc_en", 32'(acc_enable), 32'h1);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
